// File: rtl/uart_pos_link_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pos_link_if
//  Description : Bundles the game-logic side of the position link: the baud
//                divisor, the transmit request/snapshot/handshake signals and
//                the received-position outputs.
//  Ports (modport view from the link, "slave"):
//    baud_div  in   DVSR_BIT  tick divisor (tick rate = clk/baud_div)
//    tx_start  in   1         one-cycle request to send pos_in
//    pos_in    in   NCH*CW    channel k at bits [k*CW +: CW]
//    tx_busy   out  1         frame transmission in progress
//    tx_done   out  1         one-cycle pulse after the last stop bit
//    pos_out   out  NCH*CW    last valid received coordinates
//    rx_valid  out  1         one-cycle pulse when pos_out updates
//    rx_err    out  1         one-cycle pulse on checksum error or timeout
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_pos_link_if #(
   parameter int NCH      = 2,
   parameter int CW       = 10,
   parameter int DVSR_BIT = 8
);
   logic [DVSR_BIT-1:0] baud_div;
   logic                tx_start;
   logic [NCH*CW-1:0]   pos_in;
   logic                tx_busy;
   logic                tx_done;
   logic [NCH*CW-1:0]   pos_out;
   logic                rx_valid;
   logic                rx_err;

   modport master (
      output baud_div, tx_start, pos_in,
      input  tx_busy, tx_done, pos_out, rx_valid, rx_err
   );

   modport slave (
      input  baud_div, tx_start, pos_in,
      output tx_busy, tx_done, pos_out, rx_valid, rx_err
   );
endinterface
`default_nettype wire

// File: rtl/uart_pos_link.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx / uart_tx / uart_pos_link
//  Description : Framed, checksummed, bidirectional link carrying NCH
//                coordinates of CW bits.  Frame: HDR, per coordinate low byte
//                then high byte (zero-extended to 16 bits), then XOR of all
//                payload bytes.  uart_rx/uart_tx are 16x-oversampling 8N1
//                bit engines driven by a shared tick generator.
//  Ports (uart_pos_link):
//    clk    in   1   system clock
//    reset  in   1   synchronous, active-low reset
//    rx     in   1   serial input
//    tx     out  1   serial output, idle high
//    bus    slave modport of uart_pos_link_if (handshake and positions)
//  Revision    : 1.0  initial release
// ============================================================================

// ---------------------------------------------------------------------------
// 16x oversampling receiver: samples mid-bit, LSB first.
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic            rx,
   input  wire logic            s_tick,
   output logic                 rx_done_tick,
   output logic [DBIT-1:0]      dout
);
   localparam int c_SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            r_state, w_state_nxt;
   logic [c_SW-1:0]   r_s, w_s_nxt;
   logic [c_NW-1:0]   r_n, w_n_nxt;
   logic [DBIT-1:0]   r_b, w_b_nxt;
   logic [DBIT:0]     w_shift;

   assign w_shift = {rx, r_b};
   assign dout    = r_b;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_b     <= w_b_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_s_nxt      = r_s;
      w_n_nxt      = r_n;
      w_b_nxt      = r_b;
      rx_done_tick = 1'b0;
      case (r_state)
         S_IDLE: if (!rx) begin
            w_state_nxt = S_START;
            w_s_nxt     = '0;
         end
         S_START: if (s_tick) begin
            if (r_s == c_SW'(7)) begin
               w_state_nxt = S_DATA;
               w_s_nxt     = '0;
               w_n_nxt     = '0;
            end else begin
               w_s_nxt = r_s + c_SW'(1);
            end
         end
         S_DATA: if (s_tick) begin
            if (r_s == c_SW'(15)) begin
               w_s_nxt = '0;
               w_b_nxt = w_shift[DBIT:1];
               if (r_n == c_NW'(DBIT-1)) w_state_nxt = S_STOP;
               else                      w_n_nxt     = r_n + c_NW'(1);
            end else begin
               w_s_nxt = r_s + c_SW'(1);
            end
         end
         default: if (s_tick) begin
            if (r_s == c_SW'(SB_TICK-1)) begin
               w_state_nxt  = S_IDLE;
               rx_done_tick = 1'b1;
            end else begin
               w_s_nxt = r_s + c_SW'(1);
            end
         end
      endcase
   end
endmodule

// ---------------------------------------------------------------------------
// 16x oversampling transmitter.  The line only changes on a tick, so with no
// ticks (baud_div == 0) an accepted start request leaves tx idle high.
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic            tx_start,
   input  wire logic            s_tick,
   input  wire logic [DBIT-1:0] din,
   output logic                 tx_done_tick,
   output logic                 tx
);
   localparam int c_SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            r_state, w_state_nxt;
   logic [c_SW-1:0]   r_s, w_s_nxt;
   logic [c_NW-1:0]   r_n, w_n_nxt;
   logic [DBIT-1:0]   r_b, w_b_nxt;
   logic              r_tx, w_tx_nxt;

   assign tx = r_tx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_b     <= w_b_nxt;
         if (s_tick) r_tx <= w_tx_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_s_nxt      = r_s;
      w_n_nxt      = r_n;
      w_b_nxt      = r_b;
      w_tx_nxt     = 1'b1;
      tx_done_tick = 1'b0;
      case (r_state)
         S_IDLE: if (tx_start) begin
            w_state_nxt = S_START;
            w_s_nxt     = '0;
            w_b_nxt     = din;
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (s_tick) begin
               if (r_s == c_SW'(15)) begin
                  w_state_nxt = S_DATA;
                  w_s_nxt     = '0;
                  w_n_nxt     = '0;
               end else begin
                  w_s_nxt = r_s + c_SW'(1);
               end
            end
         end
         S_DATA: begin
            w_tx_nxt = r_b[0];
            if (s_tick) begin
               if (r_s == c_SW'(15)) begin
                  w_s_nxt = '0;
                  w_b_nxt = r_b >> 1;
                  if (r_n == c_NW'(DBIT-1)) w_state_nxt = S_STOP;
                  else                      w_n_nxt     = r_n + c_NW'(1);
               end else begin
                  w_s_nxt = r_s + c_SW'(1);
               end
            end
         end
         default: if (s_tick) begin
            if (r_s == c_SW'(SB_TICK-1)) begin
               w_state_nxt  = S_IDLE;
               tx_done_tick = 1'b1;
            end else begin
               w_s_nxt = r_s + c_SW'(1);
            end
         end
      endcase
   end
endmodule

// ---------------------------------------------------------------------------
// Position link top.
// ---------------------------------------------------------------------------
module uart_pos_link #(
   parameter int         NCH      = 2,
   parameter int         CW       = 10,
   parameter int         DBIT     = 8,
   parameter int         SB_TICK  = 16,
   parameter int         DVSR_BIT = 8,
   parameter logic [7:0] HDR      = 8'hA5,
   parameter int         RX_TO    = 704
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        rx,
   output logic             tx,
   uart_pos_link_if.slave   bus
);
   localparam int c_NBYTES = 2*NCH + 2;
   localparam int c_IDXW   = $clog2(c_NBYTES);
   localparam int c_PAYW   = $clog2(2*NCH);
   localparam int c_TOW    = $clog2(RX_TO + 1);
   localparam logic [DVSR_BIT-1:0] c_ONE = DVSR_BIT'(1);

   // ---------------- tick generator ----------------
   // Comparing with >= lets a shrunken divisor wrap immediately instead of
   // running the counter all the way around.
   logic [DVSR_BIT-1:0] r_tick_cnt;
   logic                w_tick;

   assign w_tick = (bus.baud_div != '0) && (r_tick_cnt == bus.baud_div - c_ONE);

   always_ff @(posedge clk) begin
      if (!reset)                                                    r_tick_cnt <= '0;
      else if (bus.baud_div == '0 || r_tick_cnt >= bus.baud_div - c_ONE) r_tick_cnt <= '0;
      else                                                           r_tick_cnt <= r_tick_cnt + c_ONE;
   end

   // ---------------- transmit path ----------------
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND, TX_WAIT} tx_state_t;

   tx_state_t          r_tx_state, w_tx_state_nxt;
   logic [NCH*CW-1:0]  r_tx_shadow;
   logic [c_IDXW-1:0]  r_tx_idx;
   logic               r_tx_done;
   logic [16*NCH-1:0]  w_tx_words;
   logic [7:0]         w_tx_chk, w_tx_byte;
   logic               w_snap, w_idx_clr, w_idx_inc, w_eng_start, w_eng_done, w_frame_done;

   // Little-endian 16-bit words give the low-then-high byte order directly.
   for (genvar k = 0; k < NCH; k++) begin : g_tx_words
      assign w_tx_words[k*16 +: 16] = 16'(r_tx_shadow[k*CW +: CW]);
   end

   always_comb begin
      w_tx_chk = '0;
      for (int j = 0; j < 2*NCH; j++) w_tx_chk = w_tx_chk ^ w_tx_words[j*8 +: 8];
   end

   always_comb begin
      w_tx_byte = HDR;
      if (r_tx_idx == c_IDXW'(c_NBYTES-1)) w_tx_byte = w_tx_chk;
      else if (r_tx_idx != '0)             w_tx_byte = w_tx_words[(int'(r_tx_idx)-1)*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (!reset) r_tx_state <= TX_IDLE;
      else        r_tx_state <= w_tx_state_nxt;
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_snap         = 1'b0;
      w_idx_clr      = 1'b0;
      w_idx_inc      = 1'b0;
      w_eng_start    = 1'b0;
      w_frame_done   = 1'b0;
      case (r_tx_state)
         TX_IDLE: if (bus.tx_start) begin
            w_snap         = 1'b1;
            w_tx_state_nxt = TX_LOAD;
         end
         TX_LOAD: begin
            w_idx_clr      = 1'b1;
            w_tx_state_nxt = TX_SEND;
         end
         TX_SEND: begin
            w_eng_start    = 1'b1;
            w_tx_state_nxt = TX_WAIT;
         end
         default: if (w_eng_done) begin
            if (r_tx_idx == c_IDXW'(c_NBYTES-1)) begin
               w_frame_done   = 1'b1;
               w_tx_state_nxt = TX_IDLE;
            end else begin
               w_idx_inc      = 1'b1;
               w_tx_state_nxt = TX_SEND;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_shadow <= '0;
         r_tx_idx    <= '0;
         r_tx_done   <= 1'b0;
      end else begin
         r_tx_done <= w_frame_done;
         if (w_snap)         r_tx_shadow <= bus.pos_in;
         if (w_idx_clr)      r_tx_idx    <= '0;
         else if (w_idx_inc) r_tx_idx    <= r_tx_idx + c_IDXW'(1);
      end
   end

   // Registered done lands on the first idle cycle, so tx_busy is already low.
   assign bus.tx_busy = (r_tx_state != TX_IDLE);
   assign bus.tx_done = r_tx_done;

   uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx (
      .clk          (clk),
      .reset        (reset),
      .tx_start     (w_eng_start),
      .s_tick       (w_tick),
      .din          (w_tx_byte),
      .tx_done_tick (w_eng_done),
      .tx           (tx)
   );

   // ---------------- receive path ----------------
   typedef enum logic [1:0] {RX_HUNT, RX_PAY, RX_CHK} rx_state_t;

   rx_state_t          r_rx_state, w_rx_state_nxt;
   logic               r_rx_meta, r_rx_sync;
   logic [16*NCH-1:0]  r_rx_shadow;
   logic [7:0]         r_rx_acc;
   logic [c_PAYW-1:0]  r_rx_cnt;
   logic [c_TOW-1:0]   r_to_cnt;
   logic [NCH*CW-1:0]  r_pos_out, w_rx_pos;
   logic               r_rx_valid, r_rx_err;
   logic [7:0]         w_rx_byte;
   logic               w_rx_done, w_timeout, w_frame_start, w_cap, w_good, w_bad;

   // Serial input crosses from the pin domain.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

   uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .rx           (r_rx_sync),
      .s_tick       (w_tick),
      .rx_done_tick (w_rx_done),
      .dout         (w_rx_byte)
   );

   // Bits above CW are dropped here but were already folded into the XOR.
   for (genvar k = 0; k < NCH; k++) begin : g_rx_pos
      assign w_rx_pos[k*CW +: CW] = r_rx_shadow[k*16 +: CW];
   end

   assign w_timeout = (r_to_cnt == c_TOW'(RX_TO));

   always_ff @(posedge clk) begin
      if (!reset) r_rx_state <= RX_HUNT;
      else        r_rx_state <= w_rx_state_nxt;
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_frame_start  = 1'b0;
      w_cap          = 1'b0;
      w_good         = 1'b0;
      w_bad          = 1'b0;
      case (r_rx_state)
         RX_HUNT: if (w_rx_done && w_rx_byte == HDR) begin
            w_frame_start  = 1'b1;
            w_rx_state_nxt = RX_PAY;
         end
         RX_PAY: begin
            if (w_rx_done) begin
               w_cap = 1'b1;
               if (r_rx_cnt == c_PAYW'(2*NCH-1)) w_rx_state_nxt = RX_CHK;
            end else if (w_timeout) begin
               w_bad          = 1'b1;
               w_rx_state_nxt = RX_HUNT;
            end
         end
         default: begin
            if (w_rx_done) begin
               if (w_rx_byte == r_rx_acc) w_good = 1'b1;
               else                       w_bad  = 1'b1;
               w_rx_state_nxt = RX_HUNT;
            end else if (w_timeout) begin
               w_bad          = 1'b1;
               w_rx_state_nxt = RX_HUNT;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rx_shadow <= '0;
         r_rx_acc    <= '0;
         r_rx_cnt    <= '0;
         r_to_cnt    <= '0;
         r_pos_out   <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_err    <= 1'b0;
      end else begin
         r_rx_valid <= w_good;
         r_rx_err   <= w_bad;
         if (w_frame_start) begin
            r_rx_acc <= '0;
            r_rx_cnt <= '0;
         end else if (w_cap) begin
            r_rx_shadow[int'(r_rx_cnt)*8 +: 8] <= w_rx_byte;
            r_rx_acc <= r_rx_acc ^ w_rx_byte;
            r_rx_cnt <= r_rx_cnt + c_PAYW'(1);
         end
         // Inter-byte timer: idle in HUNT, restarted by every received byte.
         if (r_rx_state == RX_HUNT || w_rx_done) r_to_cnt <= '0;
         else if (w_tick && !w_timeout)          r_to_cnt <= r_to_cnt + c_TOW'(1);
         if (w_good) r_pos_out <= w_rx_pos;
      end
   end

   assign bus.pos_out  = r_pos_out;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_err   = r_rx_err;
endmodule
`default_nettype wire

// File: doc/uart_pos_link.md
Name: uart_pos_link

Overview:
Parametrised successor to the fixed two-coordinate tank-position UART link. It carries NCH coordinates of CW bits each in a framed, checksummed packet, in both directions. It has a runtime-programmable baud divisor, an explicit transmit handshake and receive-side resynchronisation. It sits between the game logic (tank position registers) and the board serial pins, and reuses the existing 16x-oversampling uart_rx and uart_tx bit engines driven by an internal tick generator.

Parameters:
NCH, 2, number of coordinate channels per frame (1..8)
CW, 10, coordinate width in bits (1..16); on the wire each coordinate is zero-extended to 16 bits
DBIT, 8, data bits per byte (passed to uart_rx/uart_tx)
SB_TICK, 16, stop-bit ticks (passed to uart_rx/uart_tx)
DVSR_BIT, 8, width of baud divisor input
HDR, 8'hA5, frame header byte
RX_TO, 704, inter-byte receive timeout in ticks (about 4 byte times)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx  in  1  serial input
tx  out  1  serial output, idle high
baud_div  in  DVSR_BIT  tick divisor; tick rate = clk/baud_div
tx_start  in  1  one-cycle request to send pos_in
pos_in  in  NCH*CW  channel k at bits [k*CW +: CW]
tx_busy  out  1  frame transmission in progress
tx_done  out  1  one-cycle pulse after last byte's stop bit
pos_out  out  NCH*CW  last valid received coordinates, same packing
rx_valid  out  1  one-cycle pulse when pos_out updates
rx_err  out  1  one-cycle pulse on checksum failure or timeout

Behaviour:
- Reset (reset==0 at clk edge): tx=1, tx_busy=0, tx_done=0, pos_out=0, rx_valid=0, rx_err=0; both FSMs return to idle/HUNT; tick counter=0. Reset mid-frame aborts with no pulses.
- Tick generator: counter 0..baud_div-1; tick is high for one cycle when count==baud_div-1. baud_div==0 means no ticks. A new baud_div value takes effect at the next wrap; if count>=new value, the counter wraps to 0.
- Frame format: HDR, then for k=0..NCH-1 low byte then high byte of coordinate k, then CHK = XOR of all 2*NCH payload bytes. Total 2*NCH+2 bytes.
- TX FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE: tx_start=1 snapshots pos_in into a shadow register and goes to LOAD; tx_busy=1 from the next cycle.
  - SEND: one-cycle start to uart_tx with the current byte.
  - WAIT: holds until uart_tx tx_done_tick, then advances the byte index, or goes to IDLE after CHK with tx_done=1 and tx_busy=0 on that cycle.
  - tx_start while tx_busy=1 is ignored.
  - Changes to pos_in after the snapshot do not affect the frame in flight.
- RX FSM states: HUNT, PAY, CHK.
  - HUNT: discards bytes != HDR.
  - PAY: collects 2*NCH bytes into a shadow register while accumulating XOR; a byte equal to HDR is treated as data.
  - CHK on a match: pos_out loads the shadow (bits above CW in each 16-bit word are dropped, but they are included in CHK) and rx_valid=1 on the same cycle.
  - CHK on a mismatch: rx_err=1, pos_out unchanged.
  - CHK always returns to HUNT.
  - Timeout: in PAY/CHK, an inter-byte tick counter reset on each rx_done_tick reaching RX_TO gives rx_err=1 and a return to HUNT. The counter does not run in HUNT.
- TX and RX are fully independent and may operate simultaneously.

Test Plan:
- NCH=2, CW=10, baud_div=4; pos_in={ch1=0x0AB, ch0=0x123}; pulse tx_start -> tx bytes A5 23 01 AB 00 89, each 8N1; tx_busy high throughout; one tx_done pulse; tx_start pulses mid-frame produce no second frame.
- Loopback tx->rx, same frame -> pos_out=={0x0AB,0x123}; exactly one rx_valid; rx_err stays 0.
- Drive rx with bytes 00 FF A5 23 01 AB 00 88 -> rx_err pulse; pos_out unchanged; then A5 10 00 20 00 30 -> rx_valid, pos_out ch0=0x010, ch1=0x020.
- Drive rx with bytes A5 23 then silence for more than 704 ticks -> one rx_err pulse; a subsequent valid frame is accepted.
- Drive rx with bytes A5 FF FF 01 00 01 -> rx_valid; ch0=0x3FF (truncated); ch1=0x001.
- Assert reset for 1 cycle mid-transmission and mid-reception -> tx=1 and tx_busy=0 the next cycle; no tx_done, rx_valid or rx_err; pos_out=0. Set baud_div=0 -> no tx activity after tx_start beyond tx_busy=1.
